// File: rtl/mux_2to1.sv
// Two-input word selector with a registered shadow copy and a select-change pulse.
// Optional macro MUX_2TO1_REG_OUT_EN drives output0 from the register instead of the mux.
module mux_2to1 #(
  parameter int               WIDTH       = 32,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] input0,
  input  logic [WIDTH-1:0] input1,
  input  logic             selector,
  output logic [WIDTH-1:0] output0,
  output logic [WIDTH-1:0] output0_q,
  output logic             sel_changed
);

  logic [WIDTH-1:0] w_mux;
  logic [WIDTH-1:0] r_out_q;
  logic             r_sel_q;
  logic             r_sel_changed;

  // A plain ternary keeps X on the select visible rather than masking it.
  assign w_mux = selector ? input1 : input0;

  // Stage boundary: capture the selected word and the select history.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_q       <= RESET_VALUE;
      r_sel_q       <= 1'b0;
      r_sel_changed <= 1'b0;
    end else begin
      r_out_q       <= w_mux;
      r_sel_q       <= selector;
      r_sel_changed <= selector ^ r_sel_q;
    end
  end

  assign output0_q   = r_out_q;
  assign sel_changed = r_sel_changed;

`ifdef MUX_2TO1_REG_OUT_EN
  assign output0 = r_out_q;
`else
  assign output0 = w_mux;
`endif

endmodule

// File: tb/tb_mux_2to1.sv
// Self-checking bench for mux_2to1: directed table, clock-stopped corner, and random run
// against a behavioural model of the selector, its shadow register and change flag.
module tb_mux_2to1;

`ifdef MUX_2TO1_REG_OUT_EN
  localparam bit REG = 1'b1;
`else
  localparam bit REG = 1'b0;
`endif
  localparam logic [31:0] RV = 32'h0;

  logic        clk;
  logic        clk_en;
  logic        reset;
  logic [31:0] input0;
  logic [31:0] input1;
  logic        selector;
  logic [31:0] output0;
  logic [31:0] output0_q;
  logic        sel_changed;

  int nvec;
  int nerr;

  // behavioural model state
  logic [31:0] m_q;
  logic        m_prev_sel;
  logic        m_chg;
  bit          m_known;

  typedef struct {
    logic        rst;
    logic [31:0] in0;
    logic [31:0] in1;
    logic        sel;
    logic [31:0] exp_out;
    logic [31:0] exp_q;
    logic        exp_chg;
  } vec_t;

  vec_t tbl[11];

  mux_2to1 #(.WIDTH(32), .RESET_VALUE(RV)) dut (
    .clk        (clk),
    .reset      (reset),
    .input0     (input0),
    .input1     (input1),
    .selector   (selector),
    .output0    (output0),
    .output0_q  (output0_q),
    .sel_changed(sel_changed)
  );

  initial begin
    clk = 1'b0;
    forever begin
      #5;
      if (clk_en) clk = ~clk;
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached (nvec=%0d)", nvec);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_out_now();
    if (REG) return m_q;
    if (selector) return input1;
    return input0;
  endfunction

  task automatic model_edge();
    if (reset) begin
      m_q        = RV;
      m_prev_sel = 1'b0;
      m_chg      = 1'b0;
    end else begin
      m_chg      = (selector != m_prev_sel);
      m_prev_sel = selector;
      m_q        = selector ? input1 : input0;
    end
    m_known = 1'b1;
  endtask

  task automatic post_edge_checks(input string tag);
    chk({tag, ":q"},   output0_q, m_q);
    chk({tag, ":chg"}, {31'b0, sel_changed}, {31'b0, m_chg});
    chk({tag, ":out"}, output0, exp_out_now());
  endtask

  task automatic cyc(input logic r, input logic [31:0] a, input logic [31:0] b,
                     input logic s, input string tag);
    @(negedge clk);
    reset = r; input0 = a; input1 = b; selector = s;
    #1;
    if (m_known || !REG) chk({tag, ":out_pre"}, output0, exp_out_now());
    @(posedge clk);
    model_edge();
    #1;
    post_edge_checks(tag);
  endtask

  initial begin
    nvec = 0; nerr = 0;
    m_known = 1'b0; m_q = 'x; m_prev_sel = 1'b0; m_chg = 1'b0;
    clk_en = 1'b1;
    reset = 1'b1; input0 = 32'd5; input1 = 32'd222; selector = 1'b0;

    //          rst   in0           in1        sel   out           q             chg
    tbl[0]  = '{1'b1, 32'd5,        32'd222,   1'b0, 32'd5,        32'd0,        1'b0};
    tbl[1]  = '{1'b1, 32'd5,        32'd222,   1'b0, 32'd5,        32'd0,        1'b0};
    tbl[2]  = '{1'b0, 32'd5,        32'd222,   1'b1, 32'd222,      32'd222,      1'b1};
    tbl[3]  = '{1'b0, 32'd5,        32'd222,   1'b1, 32'd222,      32'd222,      1'b0};
    tbl[4]  = '{1'b0, 32'hFFFFFFFF, 32'd0,     1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1};
    tbl[5]  = '{1'b0, 32'hFFFFFFFF, 32'd0,     1'b1, 32'd0,        32'd0,        1'b1};
    tbl[6]  = '{1'b0, 32'hFFFFFFFF, 32'd0,     1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1};
    tbl[7]  = '{1'b0, 32'hFFFFFFFF, 32'd0,     1'b1, 32'd0,        32'd0,        1'b1};
    tbl[8]  = '{1'b1, 32'd111,      32'd222,   1'b1, 32'd222,      32'd0,        1'b0};
    tbl[9]  = '{1'b0, 32'd111,      32'd222,   1'b1, 32'd222,      32'd222,      1'b1};
    tbl[10] = '{1'b0, 32'd111,      32'd222,   1'b0, 32'd111,      32'd111,      1'b1};

    for (int i = 0; i < 11; i++) begin
      cyc(tbl[i].rst, tbl[i].in0, tbl[i].in1, tbl[i].sel, $sformatf("tbl%0d", i));
      chk($sformatf("tbl%0d:q_const", i), output0_q, tbl[i].exp_q);
      chk($sformatf("tbl%0d:chg_const", i), {31'b0, sel_changed}, {31'b0, tbl[i].exp_chg});
      chk($sformatf("tbl%0d:out_const", i), output0, REG ? tbl[i].exp_q : tbl[i].exp_out);
    end

    // Long hold on input0, then switch to input1.
    for (int i = 0; i < 50; i++) cyc(1'b0, 32'd111, 32'd222, 1'b0, "hold0");
    for (int i = 0; i < 10; i++) cyc(1'b0, 32'd111, 32'd222, 1'b1, "hold1");

    // Clock stopped: the output must keep following the inputs with no edge.
    @(negedge clk);
    clk_en = 1'b0;
    #20;
    input0 = 32'hA5A5A5A5; input1 = 32'h5A5A5A5A; selector = 1'b0;
    #1 chk("noclk:sel0", output0, exp_out_now());
    selector = 1'b1;
    #1 chk("noclk:sel1", output0, exp_out_now());
    input1 = 32'h00000001;
    #1 chk("noclk:in1", output0, exp_out_now());
    reset = 1'b1;
    #1 chk("noclk:rst_no_edge_q", output0_q, m_q);
    reset = 1'b0;
    clk_en = 1'b1;
    @(posedge clk);
    model_edge();
    #1 post_edge_checks("restart");

    // Random traffic with occasional mid-stream resets.
    for (int i = 0; i < 400; i++) begin
      logic        r;
      logic [31:0] a;
      logic [31:0] b;
      logic        s;
      r = ($urandom_range(0, 15) == 0);
      a = $urandom;
      b = (i % 7 == 0) ? a : $urandom;
      s = $urandom_range(0, 1) != 0;
      cyc(r, a, b, s, "rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
